// File: rtl/me_result_collector.sv
// Collects per-block motion-estimation results on the rising edge of data_valid,
// turns positions into signed motion vectors and queues them in a small FWFT FIFO.
module me_result_collector #(
   parameter int SAD_BIT_WIDTH  = 14,
   parameter int SEARCH_OFFSET  = 8,
   parameter int FIFO_DEPTH     = 4,
   parameter int BLOCKS_PER_FRM = 16,
   parameter int BLK_IDX_WIDTH  = 8
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              en_i,
   input  logic [SAD_BIT_WIDTH-1:0]          MSAD_i,
   input  logic [4:0]                        MSAD_column_i,
   input  logic [4:0]                        MSAD_row_i,
   input  logic                              data_valid_i,
   input  logic                              mv_ready_i,
   output logic                              mv_valid_o,
   output logic [5:0]                        mv_x_o,
   output logic [5:0]                        mv_y_o,
   output logic [SAD_BIT_WIDTH-1:0]          mv_sad_o,
   output logic [BLK_IDX_WIDTH-1:0]          blk_idx_o,
   output logic                              frame_done_o,
   output logic                              overflow_o,
   output logic [$clog2(FIFO_DEPTH):0]       fifo_count_o
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int REC_W = 12 + SAD_BIT_WIDTH + BLK_IDX_WIDTH;
   localparam logic [CNT_W-1:0]         FULL_CNT = CNT_W'(FIFO_DEPTH);
   localparam logic [5:0]               OFFSET6  = 6'(SEARCH_OFFSET);
   localparam logic [BLK_IDX_WIDTH-1:0] LAST_BLK = BLK_IDX_WIDTH'(BLOCKS_PER_FRM - 1);

   logic                     armed_reg;
   logic                     dv_q_reg;
   logic                     overflow_reg;
   logic                     frame_done_reg;
   logic [BLK_IDX_WIDTH-1:0] blk_cnt_reg;
   logic [BLK_IDX_WIDTH-1:0] blk_cnt_next;
   logic [PTR_W-1:0]         wr_ptr_reg;
   logic [PTR_W-1:0]         rd_ptr_reg;
   logic [CNT_W-1:0]         count_reg;
   logic [CNT_W-1:0]         count_next;
   logic [REC_W-1:0]         mem_reg [FIFO_DEPTH];
   logic [REC_W-1:0]         rec_next;
   logic [REC_W-1:0]         head;
   logic                     capture;
   logic                     empty;
   logic                     full;
   logic                     pop;
   logic                     push;
   logic                     drop;

   // Only a low->high transition of data_valid after an observed busy phase is a result.
   assign capture = en_i & armed_reg & data_valid_i & ~dv_q_reg;
   assign empty   = (count_reg == '0);
   assign full    = (count_reg == FULL_CNT);
   assign pop     = ~empty & mv_ready_i;
   // A pop in the same cycle frees the slot the incoming record needs.
   assign push    = capture & (~full | pop);
   assign drop    = capture & full & ~pop;

   assign rec_next = {{1'b0, MSAD_column_i} - OFFSET6,
                      {1'b0, MSAD_row_i} - OFFSET6,
                      MSAD_i,
                      blk_cnt_reg};

   assign blk_cnt_next = (blk_cnt_reg == LAST_BLK) ? '0 : blk_cnt_reg + 1'b1;

   always_comb begin
      count_next = count_reg;
      case ({push, pop})
         2'b10:   count_next = count_reg + 1'b1;
         2'b01:   count_next = count_reg - 1'b1;
         default: count_next = count_reg;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_reg[wr_ptr_reg] <= rec_next;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         armed_reg      <= 1'b0;
         dv_q_reg       <= 1'b1;
         overflow_reg   <= 1'b0;
         frame_done_reg <= 1'b0;
         blk_cnt_reg    <= '0;
         wr_ptr_reg     <= '0;
         rd_ptr_reg     <= '0;
         count_reg      <= '0;
      end else begin
         dv_q_reg <= data_valid_i;
         if (capture || !en_i) begin
            armed_reg <= 1'b0;
         end else if (!data_valid_i) begin
            armed_reg <= 1'b1;
         end
         frame_done_reg <= capture && (blk_cnt_reg == LAST_BLK);
         if (capture) begin
            blk_cnt_reg <= blk_cnt_next;
         end
         if (drop) begin
            overflow_reg <= 1'b1;
         end
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         count_reg <= count_next;
      end
   end

   // First-word-fall-through head; all record outputs read as zero when empty.
   assign head = empty ? '0 : mem_reg[rd_ptr_reg];

   assign mv_valid_o   = ~empty;
   assign mv_x_o       = head[REC_W-1 -: 6];
   assign mv_y_o       = head[REC_W-7 -: 6];
   assign mv_sad_o     = head[BLK_IDX_WIDTH +: SAD_BIT_WIDTH];
   assign blk_idx_o    = head[BLK_IDX_WIDTH-1:0];
   assign frame_done_o = frame_done_reg;
   assign overflow_o   = overflow_reg;
   assign fifo_count_o = count_reg;

endmodule

// File: tb/tb_me_result_collector.sv
// Directed bench for me_result_collector: a scoreboard queue models the FIFO,
// block counter and overflow flag; every record popped is compared with it.
module tb_me_result_collector;

   logic        clk = 1'b0;
   logic        rst;
   logic        en_i;
   logic [13:0] MSAD_i;
   logic [4:0]  MSAD_column_i;
   logic [4:0]  MSAD_row_i;
   logic        data_valid_i;
   logic        mv_ready_i;
   logic        mv_valid_o;
   logic [5:0]  mv_x_o;
   logic [5:0]  mv_y_o;
   logic [13:0] mv_sad_o;
   logic [7:0]  blk_idx_o;
   logic        frame_done_o;
   logic        overflow_o;
   logic [2:0]  fifo_count_o;

   typedef struct {
      logic [5:0]  x;
      logic [5:0]  y;
      logic [13:0] sad;
      logic [7:0]  blk;
   } rec_t;

   rec_t sb[$];
   int   exp_blk = 0;
   bit   exp_ovf = 1'b0;
   int   checks  = 0;
   int   errors  = 0;

   me_result_collector dut (
      .clk           (clk),
      .rst           (rst),
      .en_i          (en_i),
      .MSAD_i        (MSAD_i),
      .MSAD_column_i (MSAD_column_i),
      .MSAD_row_i    (MSAD_row_i),
      .data_valid_i  (data_valid_i),
      .mv_ready_i    (mv_ready_i),
      .mv_valid_o    (mv_valid_o),
      .mv_x_o        (mv_x_o),
      .mv_y_o        (mv_y_o),
      .mv_sad_o      (mv_sad_o),
      .blk_idx_o     (blk_idx_o),
      .frame_done_o  (frame_done_o),
      .overflow_o    (overflow_o),
      .fifo_count_o  (fifo_count_o)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_head();
      rec_t e;
      chk("head_valid", 32'(mv_valid_o), 32'd1);
      if (sb.size() == 0) begin
         chk("scoreboard_nonempty", 32'd0, 32'd1);
      end else begin
         e = sb[0];
         chk("head_mv_x", 32'(mv_x_o), 32'(e.x));
         chk("head_mv_y", 32'(mv_y_o), 32'(e.y));
         chk("head_sad", 32'(mv_sad_o), 32'(e.sad));
         chk("head_blk", 32'(blk_idx_o), 32'(e.blk));
         $display("pop  blk=%0d mv_x=%0d mv_y=%0d sad=%0d", blk_idx_o,
                  $signed(mv_x_o), $signed(mv_y_o), mv_sad_o);
      end
   endtask

   task automatic pop_one();
      check_head();
      if (sb.size() != 0) void'(sb.pop_front());
      mv_ready_i = 1'b1;
      tick();
      mv_ready_i = 1'b0;
   endtask

   // Busy phase of 'low' cycles, then one data_valid rising edge carrying the result.
   task automatic capture(input logic [4:0] col, input logic [4:0] row, input logic [13:0] sad,
                          input bit with_pop, input int low);
      rec_t r;
      int   blk;
      data_valid_i = 1'b0;
      repeat (low) tick();
      MSAD_column_i = col;
      MSAD_row_i    = row;
      MSAD_i        = sad;
      data_valid_i  = 1'b1;
      mv_ready_i    = with_pop;
      if (with_pop) begin
         check_head();
         if (sb.size() != 0) void'(sb.pop_front());
      end
      blk     = exp_blk;
      exp_blk = (exp_blk + 1) % 16;
      r.x   = 6'(int'(col) - 8);
      r.y   = 6'(int'(row) - 8);
      r.sad = sad;
      r.blk = 8'(blk);
      if (sb.size() < 4) sb.push_back(r);
      else exp_ovf = 1'b1;
      tick();
      mv_ready_i = 1'b0;
      $display("cap  blk=%0d col=%0d row=%0d sad=%0d pop=%0d count=%0d", blk, col, row, sad,
               with_pop, fifo_count_o);
      chk("frame_done", 32'(frame_done_o), (blk == 15) ? 32'd1 : 32'd0);
      chk("fifo_count", 32'(fifo_count_o), 32'(sb.size()));
      chk("overflow", 32'(overflow_o), 32'(exp_ovf));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      chk("rst_valid", 32'(mv_valid_o), 32'd0);
      chk("rst_count", 32'(fifo_count_o), 32'd0);
      chk("rst_overflow", 32'(overflow_o), 32'd0);
      rst = 1'b0;
      sb.delete();
      exp_blk = 0;
      exp_ovf = 1'b0;
      $display("rst  scoreboard cleared");
   endtask

   task automatic check_empty(input string tag);
      chk({tag, "_valid"}, 32'(mv_valid_o), 32'd0);
      chk({tag, "_count"}, 32'(fifo_count_o), 32'd0);
      chk({tag, "_mv_x"}, 32'(mv_x_o), 32'd0);
      chk({tag, "_sad"}, 32'(mv_sad_o), 32'd0);
   endtask

   initial begin
      rst = 1'b1; en_i = 1'b1; data_valid_i = 1'b1; mv_ready_i = 1'b0;
      MSAD_i = '0; MSAD_column_i = '0; MSAD_row_i = '0;
      repeat (3) tick();
      rst = 1'b0;
      check_empty("reset");
      chk("reset_frame_done", 32'(frame_done_o), 32'd0);
      chk("reset_blk", 32'(blk_idx_o), 32'd0);

      // T2: data_valid never drops after reset
      repeat (5) tick();
      check_empty("no_busy_phase");

      // T1: first result visible the cycle after capture
      capture(5'd10, 5'd5, 14'd300, 1'b0, 16);
      chk("t1_mv_x", 32'(mv_x_o), 32'h02);
      chk("t1_mv_y", 32'(mv_y_o), 32'h3D);
      pop_one();
      check_empty("t1_drained");

      // T3: five captures into a 4-deep FIFO with no consumer
      do_reset();
      for (int i = 0; i < 5; i++) capture(5'(i + 8), 5'(20 - i), 14'(100 + i), 1'b0, 2);
      chk("t3_overflow", 32'(overflow_o), 32'd1);
      for (int i = 0; i < 4; i++) pop_one();
      check_empty("t3_drained");
      chk("t3_overflow_sticky", 32'(overflow_o), 32'd1);

      // T4: capture and pop in the same cycle while full
      do_reset();
      for (int i = 0; i < 4; i++) capture(5'(i), 5'(i + 3), 14'(50 * i), 1'b0, 1);
      capture(5'd17, 5'd9, 14'd999, 1'b1, 3);
      chk("t4_count", 32'(fifo_count_o), 32'd4);
      chk("t4_overflow", 32'(overflow_o), 32'd0);
      for (int i = 0; i < 4; i++) pop_one();
      check_empty("t4_drained");

      // Disabled collector ignores a result and holds the block counter
      en_i = 1'b0;
      data_valid_i = 1'b0;
      repeat (3) tick();
      data_valid_i = 1'b1;
      tick();
      en_i = 1'b1;
      tick();
      check_empty("disabled");
      capture(5'd12, 5'd12, 14'd1234, 1'b0, 2);
      pop_one();

      // T5: a full frame of 16 blocks, then wrap to block 0
      do_reset();
      for (int i = 0; i < 16; i++) begin
         capture(5'(i), 5'(31 - i), 14'(i * 10), 1'b0, 2);
         pop_one();
      end
      chk("t5_frame_done_one_pulse", 32'(frame_done_o), 32'd0);
      capture(5'd8, 5'd8, 14'd77, 1'b0, 2);
      pop_one();

      // T6: extreme positions, then reset with records queued
      capture(5'd0, 5'd31, 14'd16383, 1'b0, 2);
      capture(5'd31, 5'd0, 14'd1, 1'b0, 2);
      chk("t6_mv_x_min", 32'(mv_x_o), 32'h38);
      chk("t6_mv_y_max", 32'(mv_y_o), 32'd23);
      check_head();
      do_reset();
      check_empty("t6_flushed");
      capture(5'd3, 5'd3, 14'd7, 1'b0, 2);
      pop_one();
      check_empty("final");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
